// File: rtl/semafor_pkg.sv
// Shared definitions for the two-road intersection controller: phase
// codes, LED bit positions, default timings and the lamp decode.
package semafor_pkg;

  // Phase codes; the numeric values are shown directly on led[2:0].
  typedef enum logic [2:0] {
    A_VERDE  = 3'd0,
    A_GALBEN = 3'd1,
    ROSU_1   = 3'd2,
    B_VERDE  = 3'd3,
    B_GALBEN = 3'd4,
    ROSU_2   = 3'd5,
    PIETON   = 3'd6,
    NOAPTE   = 3'd7
  } state_t;

  localparam int LED_STATE_LSB = 0;
  localparam int LED_NOAPTE    = 6;
  localparam int LED_CERERE    = 7;

  localparam int DEF_COUNT_TO = 25_000_000;
  localparam int DEF_CNT_W    = 24;
  localparam int DEF_T_VERDE  = 30;
  localparam int DEF_T_GALBEN = 3;
  localparam int DEF_T_ROSU   = 2;
  localparam int DEF_T_PIETON = 15;
  localparam int DEF_T_SCURT  = 5;

  typedef struct packed {
    logic rosu_a;
    logic galben_a;
    logic verde_a;
    logic rosu_b;
    logic galben_b;
    logic verde_b;
    logic rosu_pieton;
    logic verde_pieton;
  } lamps_t;

  // Normal phase order; ROSU_2 inserts the pedestrian phase when requested.
  function automatic state_t next_phase(input state_t s, input logic req);
    case (s)
      A_VERDE:  next_phase = A_GALBEN;
      A_GALBEN: next_phase = ROSU_1;
      ROSU_1:   next_phase = B_VERDE;
      B_VERDE:  next_phase = B_GALBEN;
      B_GALBEN: next_phase = ROSU_2;
      ROSU_2:   next_phase = req ? PIETON : A_VERDE;
      PIETON:   next_phase = A_VERDE;
      default:  next_phase = ROSU_2;
    endcase
  endfunction

  // Lamp pattern for a phase. In night mode only the two yellows blink.
  function automatic lamps_t lamps_for(input state_t s, input logic blink);
    lamps_t l;
    l              = '0;
    l.verde_a      = (s == A_VERDE);
    l.galben_a     = (s == A_GALBEN) || ((s == NOAPTE) && blink);
    l.rosu_a       = !((s == A_VERDE) || (s == A_GALBEN) || (s == NOAPTE));
    l.verde_b      = (s == B_VERDE);
    l.galben_b     = (s == B_GALBEN) || ((s == NOAPTE) && blink);
    l.rosu_b       = !((s == B_VERDE) || (s == B_GALBEN) || (s == NOAPTE));
    l.verde_pieton = (s == PIETON);
    l.rosu_pieton  = !((s == PIETON) || (s == NOAPTE));
    return l;
  endfunction

endpackage

// File: rtl/semafor_prescaler.sv
// Free-running prescaler producing a one-cycle tick every COUNT_TO clocks.
// The counter widens itself when COUNT_TO does not fit in CNT_W bits.
module semafor_prescaler #(
  parameter int COUNT_TO = 25_000_000,
  parameter int CNT_W    = 24
) (
  input  logic clk,
  input  logic rst,
  output logic pulse
);

  localparam int NEED_W = (COUNT_TO > 1) ? $clog2(COUNT_TO) : 1;
  localparam int PW     = (NEED_W > CNT_W) ? NEED_W : CNT_W;
  localparam logic [PW-1:0] LAST = PW'(COUNT_TO - 1);

  logic [PW-1:0] cnt;

  // Count 0..COUNT_TO-1 and wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + PW'(1);
    end
  end

  assign pulse = (cnt == LAST);

endmodule

// File: rtl/semafor_intersectie.sv
// Two-road intersection controller with pedestrian phase and night mode.
// Phase state is visible on led[2:0]; all lamps are registered.
module semafor_intersectie
  import semafor_pkg::*;
#(
  parameter int COUNT_TO = DEF_COUNT_TO,
  parameter int CNT_W    = DEF_CNT_W,
  parameter int T_VERDE  = DEF_T_VERDE,
  parameter int T_GALBEN = DEF_T_GALBEN,
  parameter int T_ROSU   = DEF_T_ROSU,
  parameter int T_PIETON = DEF_T_PIETON,
  parameter int T_SCURT  = DEF_T_SCURT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             buton,
  input  logic             noapte,
  output logic             pulse,
  output logic [CNT_W-1:0] count_semafor,
  output logic             rosu_a,
  output logic             galben_a,
  output logic             verde_a,
  output logic             rosu_b,
  output logic             galben_b,
  output logic             verde_b,
  output logic             rosu_pieton,
  output logic             verde_pieton,
  output logic [7:0]       led
);

  function automatic bit fits(input int v);
    return (v >= 1) && ((longint'(v) >> CNT_W) == 0);
  endfunction

  localparam bit PARAMS_OK = (T_SCURT < T_VERDE) && fits(T_VERDE) && fits(T_GALBEN) &&
                             fits(T_ROSU) && fits(T_PIETON) && fits(T_SCURT) &&
                             (COUNT_TO >= 1);

  if (!PARAMS_OK) begin : g_param_check
    $fatal(1, "semafor_intersectie: invalid timing parameters");
  end

  localparam logic [CNT_W-1:0] T_SCURT_C = CNT_W'(T_SCURT);

  function automatic logic [CNT_W-1:0] dur(input state_t s);
    case (s)
      A_VERDE, B_VERDE:   dur = CNT_W'(T_VERDE);
      A_GALBEN, B_GALBEN: dur = CNT_W'(T_GALBEN);
      ROSU_1, ROSU_2:     dur = CNT_W'(T_ROSU);
      PIETON:             dur = CNT_W'(T_PIETON);
      default:            dur = '0;
    endcase
  endfunction

  semafor_prescaler #(
    .COUNT_TO (COUNT_TO),
    .CNT_W    (CNT_W)
  ) u_prescaler (
    .clk   (clk),
    .rst   (rst),
    .pulse (pulse)
  );

  logic buton_s1, buton_s2, buton_prev;
  logic noapte_s1, noapte_s2;
  logic buton_fall;

  // Two-flop synchronisers plus the previous synchronised button level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buton_s1   <= 1'b1;
      buton_s2   <= 1'b1;
      buton_prev <= 1'b1;
      noapte_s1  <= 1'b0;
      noapte_s2  <= 1'b0;
    end else begin
      buton_s1   <= buton;
      buton_s2   <= buton_s1;
      buton_prev <= buton_s2;
      noapte_s1  <= noapte;
      noapte_s2  <= noapte_s1;
    end
  end

  assign buton_fall = buton_prev & ~buton_s2;

  state_t           state, state_n;
  logic [CNT_W-1:0] count, count_n;
  logic             cerere, cerere_n;
  logic             blink, blink_n;
  lamps_t           lamps;

  // Next phase/count: night entry and exit take priority, then the
  // pedestrian shortening load (which swallows a coincident tick), then
  // normal per-tick countdown.
  always_comb begin
    state_n = state;
    count_n = count;
    blink_n = blink;
    if (pulse && noapte_s2) begin
      state_n = NOAPTE;
      count_n = '0;
      blink_n = (state == NOAPTE) ? ~blink : 1'b1;
    end else if (pulse && (state == NOAPTE)) begin
      state_n = ROSU_2;
      count_n = dur(ROSU_2);
    end else if ((state == A_VERDE) && cerere && (count > T_SCURT_C)) begin
      count_n = T_SCURT_C;
    end else if (pulse) begin
      if (count == CNT_W'(1)) begin
        state_n = next_phase(state, cerere);
        count_n = dur(state_n);
      end else begin
        count_n = count - CNT_W'(1);
      end
    end
  end

  // Request latch: held clear in night mode, cleared on PIETON entry,
  // otherwise set by a synchronised button press.
  always_comb begin
    cerere_n = cerere;
    if (state_n == NOAPTE) begin
      cerere_n = 1'b0;
    end else if ((state_n == PIETON) && (state != PIETON)) begin
      cerere_n = 1'b0;
    end else if (buton_fall) begin
      cerere_n = 1'b1;
    end
  end

  // Phase FSM registers with registered lamp outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ROSU_2;
      count  <= CNT_W'(T_ROSU);
      cerere <= 1'b0;
      blink  <= 1'b1;
      lamps  <= lamps_for(ROSU_2, 1'b0);
    end else begin
      state  <= state_n;
      count  <= count_n;
      cerere <= cerere_n;
      blink  <= blink_n;
      lamps  <= lamps_for(state_n, blink_n);
    end
  end

  // Status LEDs: phase code, synchronised night request, pending request.
  always_comb begin
    led                             = '0;
    led[LED_STATE_LSB +: 3]         = state;
    led[LED_NOAPTE]                 = noapte_s2;
    led[LED_CERERE]                 = cerere;
  end

  assign count_semafor = count;
  assign rosu_a        = lamps.rosu_a;
  assign galben_a      = lamps.galben_a;
  assign verde_a       = lamps.verde_a;
  assign rosu_b        = lamps.rosu_b;
  assign galben_b      = lamps.galben_b;
  assign verde_b       = lamps.verde_b;
  assign rosu_pieton   = lamps.rosu_pieton;
  assign verde_pieton  = lamps.verde_pieton;

endmodule

// File: tb/tb_semafor_intersectie.sv
// Bench for semafor_intersectie: phase/timing reference model checked on
// every cycle, directed scenarios with literal expectations, then random
// button and night-mode traffic.
module tb_semafor_intersectie;

  localparam int COUNT_TO = 4;
  localparam int CNT_W    = 24;
  localparam int T_VERDE  = 6;
  localparam int T_GALBEN = 2;
  localparam int T_ROSU   = 1;
  localparam int T_PIETON = 4;
  localparam int T_SCURT  = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             buton = 1'b1;
  logic             noapte = 1'b0;
  logic             pulse;
  logic [CNT_W-1:0] count_semafor;
  logic             rosu_a, galben_a, verde_a;
  logic             rosu_b, galben_b, verde_b;
  logic             rosu_pieton, verde_pieton;
  logic [7:0]       led;

  int n_checks = 0;
  int n_fail   = 0;

  semafor_intersectie #(
    .COUNT_TO (COUNT_TO), .CNT_W (CNT_W), .T_VERDE (T_VERDE), .T_GALBEN (T_GALBEN),
    .T_ROSU (T_ROSU), .T_PIETON (T_PIETON), .T_SCURT (T_SCURT)
  ) dut (
    .clk (clk), .rst (rst), .buton (buton), .noapte (noapte), .pulse (pulse),
    .count_semafor (count_semafor),
    .rosu_a (rosu_a), .galben_a (galben_a), .verde_a (verde_a),
    .rosu_b (rosu_b), .galben_b (galben_b), .verde_b (verde_b),
    .rosu_pieton (rosu_pieton), .verde_pieton (verde_pieton), .led (led)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Phases as indices 0..7 with a duration table; inputs go through a
  // sample-history delay line; the tick is the cycle number modulo COUNT_TO.
  int dur_tab [0:7] = '{T_VERDE, T_GALBEN, T_ROSU, T_VERDE, T_GALBEN, T_ROSU, T_PIETON, 0};
  int m_cyc, m_ph, m_rem, m_old;
  bit m_req, m_blink, m_p, m_ns, m_fall;
  bit bh [0:2];
  bit nh [0:2];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cyc = 0; m_ph = 5; m_rem = T_ROSU; m_req = 0; m_blink = 1;
      for (int i = 0; i < 3; i++) begin bh[i] = 1'b1; nh[i] = 1'b0; end
    end else begin
      m_p    = (m_cyc % COUNT_TO) == (COUNT_TO - 1);
      m_ns   = nh[1];
      m_fall = bh[2] && !bh[1];
      m_old  = m_ph;
      if (m_p && m_ns) begin
        m_blink = (m_ph == 7) ? !m_blink : 1'b1;
        m_ph = 7; m_rem = 0;
      end else if (m_p && m_ph == 7) begin
        m_ph = 5; m_rem = T_ROSU;
      end else if (m_ph == 0 && m_req && m_rem > T_SCURT) begin
        m_rem = T_SCURT;
      end else if (m_p) begin
        if (m_rem > 1) m_rem = m_rem - 1;
        else begin
          m_ph  = (m_ph == 5) ? (m_req ? 6 : 0) : (m_ph == 6) ? 0 : m_ph + 1;
          m_rem = dur_tab[m_ph];
        end
      end
      if (m_ph == 7 || (m_ph == 6 && m_old != 6)) m_req = 0;
      else if (m_fall) m_req = 1;
      bh[2] = bh[1]; bh[1] = bh[0]; bh[0] = buton;
      nh[2] = nh[1]; nh[1] = nh[0]; nh[0] = noapte;
      m_cyc++;
    end
  end

  function automatic logic [40:0] exp_vec();
    logic ra, ga, va, rb, gb, vb, rp, vp;
    logic [7:0] ld;
    va = (m_ph == 0);
    ga = (m_ph == 1) || (m_ph == 7 && m_blink);
    ra = !(m_ph == 0 || m_ph == 1 || m_ph == 7);
    vb = (m_ph == 3);
    gb = (m_ph == 4) || (m_ph == 7 && m_blink);
    rb = !(m_ph == 3 || m_ph == 4 || m_ph == 7);
    vp = (m_ph == 6);
    rp = !(m_ph == 6 || m_ph == 7);
    ld = {m_req, nh[1], 3'b000, 3'(m_ph)};
    return {((m_cyc % COUNT_TO) == (COUNT_TO - 1)), CNT_W'(m_rem),
            ra, ga, va, rb, gb, vb, rp, vp, ld};
  endfunction

  // ---------------- per-cycle compare ----------------
  logic [40:0] act_v, exp_v;
  always @(negedge clk) begin
    act_v = {pulse, count_semafor, rosu_a, galben_a, verde_a, rosu_b, galben_b, verde_b,
             rosu_pieton, verde_pieton, led};
    exp_v = exp_vec();
    n_checks++;
    if (act_v !== exp_v) begin
      n_fail++;
      $display("FAIL model_cycle t=%0t actual=%h required=%h", $time, act_v, exp_v);
    end
  end

  // ---------------- driver / check tasks ----------------
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic wait_state(input logic [2:0] code, input int budget, input string nm);
    int k;
    k = 0;
    while (led[2:0] !== code && k < budget) begin @(negedge clk); k++; end
    check(nm, 32'(led[2:0] === code), 32'd1);
  endtask

  task automatic wait_count(input int target, input int budget, input string nm);
    int k;
    k = 0;
    while (count_semafor !== CNT_W'(target) && k < budget) begin @(negedge clk); k++; end
    check(nm, 32'(count_semafor === CNT_W'(target)), 32'd1);
  endtask

  task automatic phase_len(input logic [2:0] code, input int exp_cycles, input string nm);
    int k;
    k = 0;
    while (led[2:0] === code && k < 200) begin @(negedge clk); k++; end
    check(nm, k, exp_cycles);
  endtask

  task automatic press(input int n);
    buton = 1'b0;
    repeat (n) @(negedge clk);
    buton = 1'b1;
  endtask

  task automatic summary();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #1_000_000;
    n_fail++;
    $display("FAIL watchdog: actual=timeout required=finish");
    summary();
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  int exp_len [0:5] = '{T_VERDE, T_GALBEN, T_ROSU, T_VERDE, T_GALBEN, T_ROSU};
  int press_left;

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    // reset state
    check("rst_led", 32'(led), 32'h05);
    check("rst_count", 32'(count_semafor), 32'd1);
    check("rst_reds", {29'd0, rosu_a, rosu_b, rosu_pieton}, 32'h7);
    check("rst_pulse", 32'(pulse), 32'd0);
    repeat (2) @(negedge clk);
    check("pulse_cycle3", 32'(pulse), 32'd0);
    @(negedge clk);
    check("pulse_cycle4", 32'(pulse), 32'd1);
    @(negedge clk);
    check("a_verde_entry_state", 32'(led[2:0]), 32'd0);
    check("a_verde_entry_count", 32'(count_semafor), 32'd6);
    check("a_verde_entry_lamps", {30'd0, verde_a, rosu_b}, 32'h3);

    // free run: one full cycle of six phases, 72 clocks in total
    for (int i = 0; i < 6; i++) begin
      check("free_phase_code", 32'(led[2:0]), i);
      phase_len(3'(i), exp_len[i] * COUNT_TO, "free_phase_len");
    end
    check("free_back_to_a", 32'(led[2:0]), 32'd0);

    // pedestrian request with shortening
    wait_count(5, 20, "short_wait5");
    press(3);
    @(negedge clk);
    check("short_count", 32'(count_semafor), 32'd2);
    check("short_cerere", 32'(led[7]), 32'd1);
    wait_state(3'd6, 100, "ped_reached");
    check("ped_cerere_clr", 32'(led[7]), 32'd0);
    check("ped_lamps", {30'd0, verde_pieton, rosu_pieton}, 32'h2);
    check("ped_count", 32'(count_semafor), 32'd4);
    phase_len(3'd6, 16, "ped_len");
    check("ped_to_a", 32'(led[2:0]), 32'd0);

    // request at count 1: no shortening, pedestrian phase still inserted
    wait_count(1, 40, "late_wait1");
    press(3);
    @(negedge clk);
    check("late_state", 32'(led[2:0]), 32'd1);
    check("late_count", 32'(count_semafor), 32'd2);
    check("late_cerere", 32'(led[7]), 32'd1);
    wait_state(3'd6, 100, "late_ped_reached");
    wait_state(3'd0, 30, "late_back_a");

    // night mode entered during B_VERDE
    wait_state(3'd3, 100, "night_b_verde");
    noapte = 1'b1;
    wait_state(3'd7, 20, "night_entered");
    check("night_count", 32'(count_semafor), 32'd0);
    check("night_lamps1", {24'd0, rosu_a, galben_a, verde_a, rosu_b, galben_b, verde_b,
                           rosu_pieton, verde_pieton}, 32'h48);
    check("night_led6", 32'(led[6]), 32'd1);
    repeat (4) @(negedge clk);
    check("night_blink0", {30'd0, galben_a, galben_b}, 32'h0);
    repeat (4) @(negedge clk);
    check("night_blink1", {30'd0, galben_a, galben_b}, 32'h3);
    noapte = 1'b0;
    wait_state(3'd5, 20, "night_exit");
    check("night_exit_count", 32'(count_semafor), 32'd1);
    check("night_exit_reds", {29'd0, rosu_a, rosu_b, galben_a}, 32'h6);
    phase_len(3'd5, 4, "night_rosu2_len");
    check("night_to_a", 32'(led[2:0]), 32'd0);

    // asynchronous reset in the middle of PIETON
    press(3);
    wait_state(3'd6, 150, "rst_ped_reached");
    @(negedge clk);
    #3 rst = 1'b1;
    #1;
    check("arst_led", 32'(led), 32'h05);
    check("arst_count", 32'(count_semafor), 32'd1);
    check("arst_lamps", {24'd0, rosu_a, galben_a, verde_a, rosu_b, galben_b, verde_b,
                         rosu_pieton, verde_pieton}, 32'h92);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("arst_pulse3", 32'(pulse), 32'd0);
    @(negedge clk);
    check("arst_pulse4", 32'(pulse), 32'd1);

    // random button presses and night toggles, checked by the model
    press_left = 0;
    for (int i = 0; i < 2500; i++) begin
      @(negedge clk);
      if (press_left > 0) begin
        buton = 1'b0;
        press_left--;
      end else begin
        buton = 1'b1;
        if ($urandom_range(0, 59) == 0) press_left = $urandom_range(1, 6);
      end
      if ($urandom_range(0, 399) == 0) noapte = ~noapte;
    end
    noapte = 1'b0;
    buton  = 1'b1;
    repeat (4) @(negedge clk);

    summary();
    $finish;
  end

endmodule
